// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The IFU_MISALIGN_CHK_EN macro (used by ifu_fetch) enables the misaligned-redirect error state.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

package ifu_pkg;

   localparam int ADDR_W = `ADDR_WIDTH;
   localparam int INST_W = `INST_WIDTH;
   localparam logic [ADDR_W-1:0] ADDR_INIT_C = `ADDR_INIT;
   localparam logic [INST_W-1:0] INST_ZERO_C = `DATA_ZERO;
   localparam logic [ADDR_W-1:0] PC_STEP_DEF = 32'd4;
   localparam logic [ADDR_W-1:0] ALIGN_MASK  = 32'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2,
      ERR   = 2'd3
   } ifu_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Fetch buffer: synchronous FIFO with flush; pointers carry one extra wrap bit
// so full and empty are distinguished without a counter.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t wdata,
   output fetch_entry_t rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_r;
   logic [AW:0]  rd_ptr_r;
   fetch_entry_t mem_r [DEPTH];

   // pointer update; flush wins over any push or pop in the same cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         if (pop)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
   end

   // storage write
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

   assign rdata = mem_r[rd_ptr_r[AW-1:0]];
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC, one ROM read per cycle into a small buffer, valid/ready to decode.
// Optional macro IFU_MISALIGN_CHK_EN traps misaligned redirects into a sticky ERR state.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] PC_STEP    = PC_STEP_DEF
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst_n,
   output logic              o_rom_rd_en,
   output logic [ADDR_W-1:0] o_rom_rd_addr,
   input  logic [INST_W-1:0] i_rom_rd_data,
   output logic              o_ifu_valid,
   input  logic              i_idu_ready,
   output logic [INST_W-1:0] o_ifu_inst,
   output logic [ADDR_W-1:0] o_ifu_pc,
   input  logic              i_jmp_en,
   input  logic [ADDR_W-1:0] i_jmp_pc,
   input  logic              i_ifu_halt
`ifdef IFU_MISALIGN_CHK_EN
   ,
   output logic              o_ifu_misalign
`endif
);

   ifu_state_e        state_r, next_state_s;
   logic [ADDR_W-1:0] pc_r, pc_next_s;
   logic [ADDR_W-1:0] last_pc_r;
   logic [ADDR_W-1:0] jmp_pc_s;
   logic              bad_jmp_s;
   logic              rd_en_s, flush_s, pop_s;
   logic              full_s, empty_s;
   fetch_entry_t      head_s, push_entry_s;

`ifdef IFU_MISALIGN_CHK_EN
   assign jmp_pc_s       = i_jmp_pc;
   assign bad_jmp_s      = (i_jmp_pc[1:0] != 2'b00);
   assign o_ifu_misalign = (state_r == ERR);
`else
   assign jmp_pc_s  = i_jmp_pc & ~ALIGN_MASK;
   assign bad_jmp_s = 1'b0;
`endif

   // valid never looks at i_idu_ready, so decode cannot form a loop through it
   assign o_ifu_valid  = !empty_s && !i_jmp_en;
   assign pop_s        = o_ifu_valid && i_idu_ready;
   assign push_entry_s = '{pc: pc_r, inst: i_rom_rd_data};

   // state register, PC and last-popped PC
   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst_n) begin
         state_r   <= IDLE;
         pc_r      <= ADDR_INIT_C;
         last_pc_r <= ADDR_INIT_C;
      end else begin
         state_r <= next_state_s;
         pc_r    <= pc_next_s;
         if (pop_s) last_pc_r <= head_s.pc;
         else       last_pc_r <= last_pc_r;
      end
   end

   // next state, PC update, read enable and flush
   always_comb begin
      next_state_s = state_r;
      pc_next_s    = pc_r;
      rd_en_s      = 1'b0;
      flush_s      = 1'b0;
      case (state_r)
         IDLE: begin
            next_state_s = FETCH;
         end
         FETCH, HALT: begin
            if (i_jmp_en) begin
               flush_s   = 1'b1;
               pc_next_s = jmp_pc_s;
               if (bad_jmp_s)       next_state_s = ERR;
               else if (i_ifu_halt) next_state_s = HALT;
               else                 next_state_s = FETCH;
            end else if (state_r == HALT || i_ifu_halt) begin
               next_state_s = HALT;
            end else begin
               rd_en_s = !full_s || pop_s;
               if (rd_en_s) pc_next_s = pc_r + PC_STEP;
               else         pc_next_s = pc_r;
            end
         end
         ERR: begin
            next_state_s = ERR;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   ifu_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_sys_clk),
      .rst_n (i_sys_rst_n),
      .flush (flush_s),
      .push  (rd_en_s),
      .pop   (pop_s),
      .wdata (push_entry_s),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   assign o_rom_rd_en   = rd_en_s;
   assign o_rom_rd_addr = pc_r;
   assign o_ifu_inst    = empty_s ? INST_ZERO_C : head_s.inst;
   assign o_ifu_pc      = empty_s ? last_pc_r : head_s.pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed steps plus random traffic checked against
// a queue-based reference model of the fetch/decode stream.
module tb_ifu_fetch;
   import ifu_pkg::*;

   localparam int FIFO_DEPTH = 2;

   logic              clk;
   logic              i_sys_rst_n;
   logic              o_rom_rd_en;
   logic [ADDR_W-1:0] o_rom_rd_addr;
   logic [INST_W-1:0] i_rom_rd_data;
   logic              o_ifu_valid;
   logic              i_idu_ready;
   logic [INST_W-1:0] o_ifu_inst;
   logic [ADDR_W-1:0] o_ifu_pc;
   logic              i_jmp_en;
   logic [ADDR_W-1:0] i_jmp_pc;
   logic              i_ifu_halt;
`ifdef IFU_MISALIGN_CHK_EN
   logic              o_ifu_misalign;
`endif

   int total = 0;
   int bad   = 0;

   ifu_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .PC_STEP(32'd4)) dut (
      .i_sys_clk     (clk),
      .i_sys_rst_n   (i_sys_rst_n),
      .o_rom_rd_en   (o_rom_rd_en),
      .o_rom_rd_addr (o_rom_rd_addr),
      .i_rom_rd_data (i_rom_rd_data),
      .o_ifu_valid   (o_ifu_valid),
      .i_idu_ready   (i_idu_ready),
      .o_ifu_inst    (o_ifu_inst),
      .o_ifu_pc      (o_ifu_pc),
      .i_jmp_en      (i_jmp_en),
      .i_jmp_pc      (i_jmp_pc),
      .i_ifu_halt    (i_ifu_halt)
`ifdef IFU_MISALIGN_CHK_EN
      ,
      .o_ifu_misalign(o_ifu_misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: address-dependent so a wrong address shows up as wrong data
   function automatic logic [INST_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return (a * 32'd3) + 32'h0000_0013;
   endfunction

   assign i_rom_rd_data = rom_word(o_rom_rd_addr);

   // reference model: queue of buffered entries plus the PC and run mode
   fetch_entry_t      q[$];
   logic [ADDR_W-1:0] m_pc;
   bit                m_known  = 1'b0;
   bit                m_warm   = 1'b0;
   bit                m_halted = 1'b0;
   bit                m_dead   = 1'b0;
   bit                obs_valid;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit rst_n_v, input bit rdy, input bit jmp, input bit hlt,
                      input logic [ADDR_W-1:0] jpc);
      bit ev;
      bit er;
      @(negedge clk);
      i_sys_rst_n = rst_n_v;
      i_idu_ready = rdy;
      i_jmp_en    = jmp;
      i_jmp_pc    = jpc;
      i_ifu_halt  = hlt;
      #1;
      ev = (q.size() > 0) && !jmp;
      er = !m_warm && !m_dead && !m_halted && !jmp && !hlt &&
           ((q.size() < FIFO_DEPTH) || (ev && rdy));
      obs_valid = o_ifu_valid;
      if (m_known) begin
         chk("valid", {63'd0, o_ifu_valid}, {63'd0, ev});
         chk("rd_en", {63'd0, o_rom_rd_en}, {63'd0, er});
         chk("rd_addr", {32'd0, o_rom_rd_addr}, {32'd0, m_pc});
         if (ev) begin
            chk("head_pc", {32'd0, o_ifu_pc}, {32'd0, q[0].pc});
            chk("head_inst", {32'd0, o_ifu_inst}, {32'd0, q[0].inst});
         end
`ifdef IFU_MISALIGN_CHK_EN
         chk("misalign", {63'd0, o_ifu_misalign}, {63'd0, m_dead});
`endif
      end
      @(posedge clk);
      if (!rst_n_v) begin
         q.delete();
         m_pc     = ADDR_INIT_C;
         m_warm   = 1'b1;
         m_halted = 1'b0;
         m_dead   = 1'b0;
         m_known  = 1'b1;
      end else if (m_warm) begin
         m_warm = 1'b0;
      end else if (m_dead) begin
         m_dead = 1'b1;
      end else if (jmp) begin
         q.delete();
`ifdef IFU_MISALIGN_CHK_EN
         m_pc   = jpc;
         m_dead = (jpc % 4) != 0;
`else
         m_pc   = jpc - (jpc % 4);
`endif
         m_halted = hlt;
      end else begin
         if (ev && rdy) void'(q.pop_front());
         if (er) begin
            q.push_back('{pc: m_pc, inst: rom_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
         if (hlt) m_halted = 1'b1;
      end
   endtask

   initial begin
      int first;
      i_sys_rst_n = 1'b0;
      i_idu_ready = 1'b0;
      i_jmp_en    = 1'b0;
      i_jmp_pc    = '0;
      i_ifu_halt  = 1'b0;

      // reset state
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk); #1;
      chk("rst_inst", {32'd0, o_ifu_inst}, {32'd0, INST_ZERO_C});
      chk("rst_pc", {32'd0, o_ifu_pc}, {32'd0, ADDR_INIT_C});
      chk("rst_valid", {63'd0, o_ifu_valid}, 64'd0);

      // streaming: first valid two cycles after release
      first = -1;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
         if (obs_valid && first < 0) first = i;
      end
      chk("first_valid_cycle", 64'(first), 64'd2);

      // back-pressure then release
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      chk("fill_level", 64'(q.size()), 64'd2);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);

      // redirect while full: valid two cycles later at the target
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, ADDR_INIT_C + 32'h100);
      first = -1;
      for (int i = 1; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
         if (obs_valid && first < 0) first = i;
      end
      chk("redirect_latency", 64'(first), 64'd2);

      // halt with two buffered: drain, then redirect resumes
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      chk("halt_drained", 64'(q.size()), 64'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, ADDR_INIT_C + 32'h200);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);

      // halt and redirect together, then PC wrap
      cyc(1'b1, 1'b1, 1'b1, 1'b1, ADDR_INIT_C + 32'h300);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8);
      for (int i = 0; i < 6; i++) cyc(1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b0, '0);

      // reset mid-stream with entries buffered
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      chk("mid_rst_addr", {32'd0, o_rom_rd_addr}, {32'd0, ADDR_INIT_C});
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [ADDR_W-1:0] t;
         t = ADDR_INIT_C + ($urandom_range(0, 255) * 32'd4);
`ifndef IFU_MISALIGN_CHK_EN
         t = t + 32'($urandom_range(0, 3));
`endif
         cyc($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, t);
      end

      // misaligned redirect
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, ADDR_INIT_C + 32'h102);
      first = -1;
      for (int i = 1; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
         if (obs_valid && first < 0) first = i;
      end
`ifdef IFU_MISALIGN_CHK_EN
      chk("misalign_no_valid", 64'(first), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("misalign_flag", {63'd0, o_ifu_misalign}, 64'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      chk("misalign_cleared", {63'd0, o_ifu_misalign}, 64'd0);
`else
      chk("misalign_resume", 64'(first), 64'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
